// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle processor control path.
//   - opcode encodings (instruction bits [7:4])
//   - ALU operation codes driven on aluOp
//   - FSM state encoding (3-bit; encodings 6 and 7 are unused)
//   - ctrl_t: the full control word produced by ctrl_decode
//   - small opcode-class helper functions
package multicycle_ctrl_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal_op;
        logic       halted;
    } ctrl_t;

    // ADD/SUB/AND/OR occupy opcodes 0..3, so aluOp is simply opcode[1:0].
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return is_alu_op(op) || is_mem_op(op) ||
               (op == OP_BEQ) || (op == OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decoder.
// Maps {state, latched opcode, zero, memReady} to the datapath control word.
// Outputs are Moore-style (state + latched opcode); the only exceptions are the
// FETCH irWrite/pcWrite (qualified by memReady so the IR/PC load exactly once
// when the fetch completes) and the BEQ pcWrite (taken from zero).
// Ports:
//   state_i      current FSM state
//   opcode_i     latched instruction opcode
//   zero_i       ALU zero flag
//   mem_ready_i  memory completes the current request this cycle
//   ctrl_o       control word; every field defaults to 0
import multicycle_ctrl_pkg::*;

module ctrl_decode (
    input  state_e     state_i,
    input  logic [3:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req = 1'b1;
                if (mem_ready_i) begin
                    ctrl_o.ir_write = 1'b1;
                    ctrl_o.pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode_i == OP_JMP) begin
                    ctrl_o.pc_write = 1'b1;
                    ctrl_o.pc_src   = 1'b1;
                end else if (!is_legal_op(opcode_i)) begin
                    ctrl_o.illegal_op = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_alu_op(opcode_i)) begin
                    ctrl_o.alu_op = opcode_i[1:0];
                end else if (is_mem_op(opcode_i)) begin
                    ctrl_o.alu_src_b = 1'b1;
                    ctrl_o.alu_op    = ALU_ADD;
                end else if (opcode_i == OP_BEQ) begin
                    ctrl_o.alu_op   = ALU_SUB;
                    ctrl_o.pc_write = zero_i;
                    ctrl_o.pc_src   = 1'b1;
                end
            end
            S_MEM: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.mem_write = (opcode_i == OP_STORE);
            end
            S_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = (opcode_i == OP_LOAD);
            end
            S_HALTED: begin
                ctrl_o.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit processor.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath enables and mux selects, handles the memory wait handshake and
// counts retired instructions (saturating).
// Memory handshake: memReq is held while in FETCH or MEM; the request completes
// in any cycle where memReq=1 and memReady=1. memReady is ignored elsewhere.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   opcode         instruction opcode, latched when irWrite=1
//   zero           ALU zero flag (same cycle)
//   memReady       memory completes the current request
//   memReq..halted control outputs (see ctrl_decode)
//   retired        retired-instruction count, saturating at all-ones
//   state_o        current FSM state (debug)
import multicycle_ctrl_pkg::*;

module multicycle_ctrl #(
    parameter int OP_W    = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    input  logic               memReady,
    output logic               memReq,
    output logic               memWrite,
    output logic               iOrD,
    output logic               irWrite,
    output logic               pcWrite,
    output logic               pcSrc,
    output logic               aluSrcB,
    output logic [1:0]         aluOp,
    output logic               regWrite,
    output logic               memToReg,
    output logic               illegalOp,
    output logic               halted,
    output logic [COUNT_W-1:0] retired,
    output logic [2:0]         state_o
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     opcode_q;
    logic [COUNT_W-1:0]  retired_q, retired_d;
    ctrl_t               ctrl;
    logic                retire;

    ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_q[3:0]),
        .zero_i      (zero),
        .mem_ready_i (memReady),
        .ctrl_o      (ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            if (ctrl.ir_write) begin
                opcode_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode_q[3:0] == OP_HALT)       state_d = S_HALTED;
                else if (opcode_q[3:0] == OP_JMP)   state_d = S_FETCH;
                else if (is_legal_op(opcode_q[3:0])) state_d = S_EXEC;
                else                                 state_d = S_FETCH;
            end
            S_EXEC: begin
                if (is_alu_op(opcode_q[3:0]))      state_d = S_WB;
                else if (is_mem_op(opcode_q[3:0])) state_d = S_MEM;
                else                               state_d = S_FETCH;
            end
            S_MEM: begin
                if (memReady) begin
                    state_d = (opcode_q[3:0] == OP_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    // An instruction retires on any return to FETCH from the execution states;
    // recovery from an unused encoding is not an instruction.
    always_comb begin
        retire = (state_d == S_FETCH) &&
                 ((state_q == S_DECODE) || (state_q == S_EXEC) ||
                  (state_q == S_MEM)    || (state_q == S_WB));
        retired_d = retired_q;
        if (retire && (retired_q != {COUNT_W{1'b1}})) begin
            retired_d = retired_q + 1'b1;
        end
    end

    assign memReq    = ctrl.mem_req;
    assign memWrite  = ctrl.mem_write;
    assign iOrD      = ctrl.i_or_d;
    assign irWrite   = ctrl.ir_write;
    assign pcWrite   = ctrl.pc_write;
    assign pcSrc     = ctrl.pc_src;
    assign aluSrcB   = ctrl.alu_src_b;
    assign aluOp     = ctrl.alu_op;
    assign regWrite  = ctrl.reg_write;
    assign memToReg  = ctrl.mem_to_reg;
    assign illegalOp = ctrl.illegal_op;
    assign halted    = ctrl.halted;
    assign retired   = retired_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. A second instance with a 3-bit counter shares all
// inputs so counter saturation is reached within a short run.
module tb_multicycle_ctrl;

    // Control word packing: {memReq,memWrite,iOrD}_{irWrite,pcWrite,pcSrc}_
    //                       {aluSrcB,aluOp}_{regWrite,memToReg}_{illegalOp,halted}
    localparam logic [12:0] C_FETCH_W = 13'b100_000_000_00_00;
    localparam logic [12:0] C_FETCH_R = 13'b100_110_000_00_00;
    localparam logic [12:0] C_NONE    = 13'b000_000_000_00_00;
    localparam logic [12:0] C_JMP     = 13'b000_011_000_00_00;
    localparam logic [12:0] C_ILL     = 13'b000_000_000_00_10;
    localparam logic [12:0] C_EX_SUB  = 13'b000_000_001_00_00;
    localparam logic [12:0] C_EX_MEM  = 13'b000_000_100_00_00;
    localparam logic [12:0] C_BEQ_T   = 13'b000_011_001_00_00;
    localparam logic [12:0] C_BEQ_N   = 13'b000_001_001_00_00;
    localparam logic [12:0] C_MEM_LD  = 13'b101_000_000_00_00;
    localparam logic [12:0] C_MEM_ST  = 13'b111_000_000_00_00;
    localparam logic [12:0] C_WB_ALU  = 13'b000_000_000_10_00;
    localparam logic [12:0] C_WB_LD   = 13'b000_000_000_11_00;
    localparam logic [12:0] C_HALT    = 13'b000_000_000_00_01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  opcode;
    logic        zero;
    logic        memReady;

    logic        memReq, memWrite, iOrD, irWrite, pcWrite, pcSrc, aluSrcB;
    logic [1:0]  aluOp;
    logic        regWrite, memToReg, illegalOp, halted;
    logic [15:0] retired;
    logic [2:0]  state;

    logic        s_memReq, s_memWrite, s_iOrD, s_irWrite, s_pcWrite, s_pcSrc, s_aluSrcB;
    logic [1:0]  s_aluOp;
    logic        s_regWrite, s_memToReg, s_illegalOp, s_halted;
    logic [2:0]  s_retired;
    logic [2:0]  s_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  op;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [12:0] ctl;
        logic [15:0] ret;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.OP_W(4), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
        .memReq(memReq), .memWrite(memWrite), .iOrD(iOrD), .irWrite(irWrite),
        .pcWrite(pcWrite), .pcSrc(pcSrc), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .regWrite(regWrite), .memToReg(memToReg), .illegalOp(illegalOp),
        .halted(halted), .retired(retired), .state_o(state)
    );

    multicycle_ctrl #(.OP_W(4), .COUNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
        .memReq(s_memReq), .memWrite(s_memWrite), .iOrD(s_iOrD), .irWrite(s_irWrite),
        .pcWrite(s_pcWrite), .pcSrc(s_pcSrc), .aluSrcB(s_aluSrcB), .aluOp(s_aluOp),
        .regWrite(s_regWrite), .memToReg(s_memToReg), .illegalOp(s_illegalOp),
        .halted(s_halted), .retired(s_retired), .state_o(s_state)
    );

    function automatic logic [12:0] ctl_now();
        return {memReq, memWrite, iOrD, irWrite, pcWrite, pcSrc, aluSrcB, aluOp,
                regWrite, memToReg, illegalOp, halted};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Checks both instances: full control word, state and counters.
    task automatic chk_all(input string tag, input logic [2:0] st,
                           input logic [12:0] ctl, input logic [15:0] ret);
        logic [2:0] sat_exp;
        sat_exp = (ret > 16'd7) ? 3'd7 : ret[2:0];
        chk({tag, " ctl"},     {19'd0, ctl_now()}, {19'd0, ctl});
        chk({tag, " state"},   {29'd0, state},     {29'd0, st});
        chk({tag, " retired"}, {16'd0, retired},   {16'd0, ret});
        chk({tag, " sat_ret"}, {29'd0, s_retired}, {29'd0, sat_exp});
    endtask

    task automatic add(input logic [3:0] op, input logic z, input logic rdy,
                       input logic [2:0] st, input logic [12:0] ctl, input logic [15:0] ret);
        vec_t v;
        v = '{op: op, z: z, rdy: rdy, st: st, ctl: ctl, ret: ret};
        vq.push_back(v);
    endtask

    initial begin
        // Instruction stream; opcode 4'hE is filler in cycles where it must be ignored.
        // ADD
        add(4'h0, 0, 0, 3'd0, C_FETCH_W, 16'd0);
        add(4'h0, 0, 1, 3'd0, C_FETCH_R, 16'd0);
        add(4'hE, 0, 0, 3'd1, C_NONE,    16'd0);
        add(4'hE, 0, 0, 3'd2, C_NONE,    16'd0);
        add(4'hE, 0, 1, 3'd4, C_WB_ALU,  16'd0);
        // SUB
        add(4'h1, 0, 1, 3'd0, C_FETCH_R, 16'd1);
        add(4'hE, 0, 0, 3'd1, C_NONE,    16'd1);
        add(4'hE, 0, 0, 3'd2, C_EX_SUB,  16'd1);
        add(4'hE, 0, 0, 3'd4, C_WB_ALU,  16'd1);
        // LOAD with two wait cycles in MEM (7 cycles total)
        add(4'h8, 0, 1, 3'd0, C_FETCH_R, 16'd2);
        add(4'hE, 0, 1, 3'd1, C_NONE,    16'd2);
        add(4'hE, 0, 1, 3'd2, C_EX_MEM,  16'd2);
        add(4'hE, 0, 0, 3'd3, C_MEM_LD,  16'd2);
        add(4'hE, 0, 0, 3'd3, C_MEM_LD,  16'd2);
        add(4'hE, 0, 1, 3'd3, C_MEM_LD,  16'd2);
        add(4'hE, 0, 0, 3'd4, C_WB_LD,   16'd2);
        // BEQ taken
        add(4'hC, 0, 1, 3'd0, C_FETCH_R, 16'd3);
        add(4'hE, 1, 0, 3'd1, C_NONE,    16'd3);
        add(4'hE, 1, 0, 3'd2, C_BEQ_T,   16'd3);
        // BEQ not taken
        add(4'hC, 1, 1, 3'd0, C_FETCH_R, 16'd4);
        add(4'hE, 0, 0, 3'd1, C_NONE,    16'd4);
        add(4'hE, 0, 0, 3'd2, C_BEQ_N,   16'd4);
        // STORE, memory already ready on entry to MEM
        add(4'h9, 0, 1, 3'd0, C_FETCH_R, 16'd5);
        add(4'hE, 0, 1, 3'd1, C_NONE,    16'd5);
        add(4'hE, 0, 1, 3'd2, C_EX_MEM,  16'd5);
        add(4'hE, 0, 1, 3'd3, C_MEM_ST,  16'd5);
        // JMP
        add(4'hD, 0, 1, 3'd0, C_FETCH_R, 16'd6);
        add(4'hE, 0, 1, 3'd1, C_JMP,     16'd6);
        // illegal opcode 5: one-cycle pulse, then FETCH
        add(4'h5, 0, 1, 3'd0, C_FETCH_R, 16'd7);
        add(4'hE, 0, 1, 3'd1, C_ILL,     16'd7);
        add(4'h0, 0, 0, 3'd0, C_FETCH_W, 16'd8);
        // HALT: not counted, stuck with no memReq
        add(4'hF, 0, 1, 3'd0, C_FETCH_R, 16'd8);
        add(4'hE, 0, 1, 3'd1, C_NONE,    16'd8);
        add(4'hE, 0, 1, 3'd5, C_HALT,    16'd8);
        add(4'h0, 0, 1, 3'd5, C_HALT,    16'd8);
        add(4'h0, 0, 1, 3'd5, C_HALT,    16'd8);

        // Reset held with memReady low for 3 cycles
        rst_n = 1'b0; opcode = 4'h0; zero = 1'b0; memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk_all("reset", 3'd0, C_FETCH_W, 16'd0);
        end
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            opcode = vq[i].op; zero = vq[i].z; memReady = vq[i].rdy;
            #1;
            chk_all($sformatf("vec%0d", i), vq[i].st, vq[i].ctl, vq[i].ret);
        end

        // Only reset leaves HALTED
        @(negedge clk);
        rst_n = 1'b0; memReady = 1'b0; opcode = 4'h9;
        #1;
        chk_all("halt_reset", 3'd0, C_FETCH_W, 16'd0);

        // STORE interrupted by reset while waiting in MEM
        @(negedge clk);
        rst_n = 1'b1; memReady = 1'b1;
        #1; chk_all("st_fetch", 3'd0, C_FETCH_R, 16'd0);
        @(negedge clk); opcode = 4'hE; #1; chk_all("st_decode", 3'd1, C_NONE, 16'd0);
        @(negedge clk); memReady = 1'b0; #1; chk_all("st_exec", 3'd2, C_EX_MEM, 16'd0);
        @(negedge clk); #1; chk_all("st_mem", 3'd3, C_MEM_ST, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_memWrite", {31'd0, memWrite}, 32'd0);
        chk_all("st_async_rst", 3'd0, C_FETCH_W, 16'd0);
        @(negedge clk); #1; chk_all("st_rst_hold", 3'd0, C_FETCH_W, 16'd0);
        rst_n = 1'b1;

        // ADD after reset: counter restarts from zero
        @(negedge clk); opcode = 4'h0; memReady = 1'b1; #1;
        chk_all("add2_fetch", 3'd0, C_FETCH_R, 16'd0);
        @(negedge clk); opcode = 4'hE; #1; chk_all("add2_decode", 3'd1, C_NONE, 16'd0);
        @(negedge clk); #1; chk_all("add2_exec", 3'd2, C_NONE, 16'd0);
        @(negedge clk); #1; chk_all("add2_wb", 3'd4, C_WB_ALU, 16'd0);
        @(negedge clk); memReady = 1'b0; #1; chk_all("add2_done", 3'd0, C_FETCH_W, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
